// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite compositing path feeding color_mapper.
// Layer ids double as priority: lower id wins.
package sprite_pkg;

  localparam int IDX_W        = 4;
  localparam int NUM_LAYERS   = 4;
  localparam int FLASH_FRAMES = 16;

  typedef logic [IDX_W-1:0]      palette_idx_t;
  typedef logic [NUM_LAYERS-1:0] layer_vec_t;

  localparam palette_idx_t TRANSPARENT_IDX = '0;

  localparam logic [1:0] LAYER_PLAYER = 2'd0;
  localparam logic [1:0] LAYER_BULLET = 2'd1;
  localparam logic [1:0] LAYER_ENEMY  = 2'd2;
  localparam logic [1:0] LAYER_FX     = 2'd3;

endpackage

// File: rtl/flash_timer.sv
// Per-layer damage-flash counter: counts frames down from FLASH_FRAMES and hides
// the layer on odd counts, giving a blink that ends visible.
module flash_timer #(
  parameter int FLASH_FRAMES = 16
) (
  input  logic Clk,
  input  logic Reset,
  input  logic i_load,
  input  logic i_frame_start,
  output logic o_hide
);

  localparam int            CW       = $clog2(FLASH_FRAMES + 1);
  localparam logic [CW-1:0] LOAD_VAL = CW'(FLASH_FRAMES);
  localparam logic [CW-1:0] ONE      = CW'(1);

  logic [CW-1:0] r_count;

  // A load takes precedence over a coincident frame decrement.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= LOAD_VAL;
    end else if (i_frame_start && (r_count != '0)) begin
      r_count <= r_count - ONE;
    end
  end

  assign o_hide = (r_count != '0) && r_count[0];

endmodule

// File: rtl/sprite_layer_arbiter.sv
// Two-stage per-pixel sprite compositor: opacity in stage 1, fixed-priority
// select in stage 2, plus frame-synchronous enables, flash and collision reporting.
module sprite_layer_arbiter #(
  parameter int NUM_LAYERS   = sprite_pkg::NUM_LAYERS,
  parameter int FLASH_FRAMES = sprite_pkg::FLASH_FRAMES,
  parameter int IDX_W        = sprite_pkg::IDX_W
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic                        frame_start,
  input  logic                        in_active,
  input  logic [9:0]                  DrawX,
  input  logic [9:0]                  DrawY,
  input  logic [NUM_LAYERS-1:0]       layer_hit,
  input  logic [NUM_LAYERS*IDX_W-1:0] layer_index,
  input  logic [NUM_LAYERS-1:0]       layer_en_next,
  input  logic [NUM_LAYERS-1:0]       flash_req,
  output logic [IDX_W-1:0]            sprite_data,
  output logic [1:0]                  win_layer,
  output logic [9:0]                  DrawX_d,
  output logic [9:0]                  DrawY_d,
  output logic [NUM_LAYERS-1:0]       collide_mask,
  output logic                        collide_valid
);

  import sprite_pkg::*;

  localparam logic [NUM_LAYERS-1:0] ONE_VEC = NUM_LAYERS'(1);

  logic [NUM_LAYERS-1:0]       r_en_active;
  logic [NUM_LAYERS-1:0]       r_acc;
  logic [NUM_LAYERS-1:0]       r_opaque;
  logic [NUM_LAYERS*IDX_W-1:0] r_index;
  logic [9:0]                  r_x1;
  logic [9:0]                  r_y1;

  logic [NUM_LAYERS-1:0] w_hide;
  logic [NUM_LAYERS-1:0] w_opaque;
  logic [NUM_LAYERS-1:0] w_contrib;
  logic                  w_multi;
  logic [IDX_W-1:0]      w_sel_idx;
  logic [1:0]            w_sel_id;

  for (genvar g = 0; g < NUM_LAYERS; g++) begin : g_flash
    flash_timer #(
      .FLASH_FRAMES (FLASH_FRAMES)
    ) u_flash (
      .Clk           (Clk),
      .Reset         (Reset),
      .i_load        (flash_req[g]),
      .i_frame_start (frame_start),
      .o_hide        (w_hide[g])
    );
  end

  always_comb begin
    w_opaque = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      w_opaque[i] = in_active && layer_hit[i] && r_en_active[i] && !w_hide[i] &&
                    (layer_index[i*IDX_W +: IDX_W] != IDX_W'(TRANSPARENT_IDX));
    end
  end

  // Two or more bits set: clearing the lowest set bit leaves something behind.
  assign w_multi   = (w_opaque & (w_opaque - ONE_VEC)) != '0;
  assign w_contrib = w_multi ? w_opaque : '0;

  // Enables only move on frame_start so a frame is always drawn with one set.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_en_active <= '1;
    end else if (frame_start) begin
      r_en_active <= layer_en_next;
    end
  end

  // The frame_start pixel seeds the new accumulation window instead of the old one.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_acc         <= '0;
      collide_mask  <= '0;
      collide_valid <= 1'b0;
    end else begin
      collide_valid <= frame_start;
      if (frame_start) begin
        collide_mask <= r_acc;
        r_acc        <= w_contrib;
      end else begin
        r_acc <= r_acc | w_contrib;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_opaque <= '0;
      r_index  <= '0;
      r_x1     <= '0;
      r_y1     <= '0;
    end else begin
      r_opaque <= w_opaque;
      r_index  <= layer_index;
      r_x1     <= DrawX;
      r_y1     <= DrawY;
    end
  end

  // Scan from lowest priority upward so the lowest-numbered opaque layer lands last.
  always_comb begin
    w_sel_idx = '0;
    w_sel_id  = '0;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (r_opaque[i]) begin
        w_sel_idx = r_index[i*IDX_W +: IDX_W];
        w_sel_id  = 2'(i);
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      sprite_data <= '0;
      win_layer   <= '0;
      DrawX_d     <= '0;
      DrawY_d     <= '0;
    end else begin
      sprite_data <= w_sel_idx;
      win_layer   <= w_sel_id;
      DrawX_d     <= r_x1;
      DrawY_d     <= r_y1;
    end
  end

endmodule

// File: tb/tb_sprite_layer_arbiter.sv
// Directed bench for sprite_layer_arbiter: vector table for the compositor plus
// hand sequences for latency, enables, flash and collision reporting.
module tb_sprite_layer_arbiter;
  import sprite_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        frame_start;
  logic        in_active;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic [3:0]  layer_hit;
  logic [15:0] layer_index;
  logic [3:0]  layer_en_next;
  logic [3:0]  flash_req;
  logic [3:0]  sprite_data;
  logic [1:0]  win_layer;
  logic [9:0]  DrawX_d;
  logic [9:0]  DrawY_d;
  logic [3:0]  collide_mask;
  logic        collide_valid;

  int n_checks = 0;
  int n_miss   = 0;

  typedef struct packed {
    logic        act;
    logic [3:0]  hit;
    logic [15:0] idx;
    logic [3:0]  exp_d;
    logic [1:0]  exp_w;
  } vec_t;

  vec_t        vecs[9];
  logic [25:0] exp_q[$];
  logic [25:0] e;

  sprite_layer_arbiter dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .frame_start   (frame_start),
    .in_active     (in_active),
    .DrawX         (DrawX),
    .DrawY         (DrawY),
    .layer_hit     (layer_hit),
    .layer_index   (layer_index),
    .layer_en_next (layer_en_next),
    .flash_req     (flash_req),
    .sprite_data   (sprite_data),
    .win_layer     (win_layer),
    .DrawX_d       (DrawX_d),
    .DrawY_d       (DrawY_d),
    .collide_mask  (collide_mask),
    .collide_valid (collide_valid)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic fs, input logic act, input logic [3:0] hit,
                       input logic [15:0] idx, input logic [3:0] fr,
                       input logic [9:0] x, input logic [9:0] y);
    frame_start = fs;
    in_active   = act;
    layer_hit   = hit;
    layer_index = idx;
    flash_req   = fr;
    DrawX       = x;
    DrawY       = y;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    layer_en_next = 4'b1111;
    drive(1'b0, 1'b1, 4'b0000, 16'hD975, 4'b0000, 10'd0, 10'd0);
    tick();
    tick();
    Reset = 1'b0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_pix(input string tag, input logic [3:0] d, input logic [1:0] w);
    check({tag, "_data"}, 32'(sprite_data), 32'(d));
    check({tag, "_win"},  32'(win_layer),   32'(w));
  endtask

  task automatic check_coll(input string tag, input logic [3:0] m, input logic v);
    check({tag, "_mask"},  32'(collide_mask),  32'(m));
    check({tag, "_valid"}, 32'(collide_valid), 32'(v));
  endtask

  initial begin
    vecs[0] = '{1'b1, 4'b1111, 16'hD975, 4'd5,  LAYER_PLAYER};
    vecs[1] = '{1'b1, 4'b0101, 16'hD970, 4'd9,  LAYER_ENEMY};
    vecs[2] = '{1'b0, 4'b0101, 16'hD970, 4'd0,  LAYER_PLAYER};
    vecs[3] = '{1'b1, 4'b0000, 16'hD975, 4'd0,  LAYER_PLAYER};
    vecs[4] = '{1'b1, 4'b1000, 16'hD975, 4'd13, LAYER_FX};
    vecs[5] = '{1'b1, 4'b1110, 16'hD975, 4'd7,  LAYER_BULLET};
    vecs[6] = '{1'b1, 4'b1111, 16'h0000, 4'd0,  LAYER_PLAYER};
    vecs[7] = '{1'b1, 4'b1100, 16'h0F75, 4'd15, LAYER_ENEMY};
    vecs[8] = '{1'b1, 4'b1010, 16'h3975, 4'd7,  LAYER_BULLET};

    // Reset values, then the first post-reset output is still background.
    Reset = 1'b1;
    layer_en_next = 4'b1111;
    drive(1'b0, 1'b1, 4'b1111, 16'hD975, 4'b0000, 10'd0, 10'd0);
    tick(); tick(); tick();
    check_pix("rst", 4'd0, 2'd0);
    check("rst_x", 32'(DrawX_d), 32'd0);
    check("rst_y", 32'(DrawY_d), 32'd0);
    check_coll("rst", 4'b0000, 1'b0);
    Reset = 1'b0;
    drive(1'b0, 1'b1, 4'b1111, 16'hD975, 4'b0000, 10'd7, 10'd9);
    tick();
    check_pix("post_rst1", 4'd0, 2'd0);
    check("post_rst1_x", 32'(DrawX_d), 32'd0);
    tick();
    check_pix("post_rst2", 4'd5, LAYER_PLAYER);
    check("post_rst2_x", 32'(DrawX_d), 32'd7);
    check("post_rst2_y", 32'(DrawY_d), 32'd9);

    // Vector table, each pixel held long enough to reach the output.
    for (int i = 0; i < 9; i++) begin
      drive(1'b0, vecs[i].act, vecs[i].hit, vecs[i].idx, 4'b0000,
            10'(10 * i + 1), 10'(5 * i + 2));
      tick(); tick();
      check_pix($sformatf("vec%0d", i), vecs[i].exp_d, vecs[i].exp_w);
      check($sformatf("vec%0d_x", i), 32'(DrawX_d), 32'(10 * i + 1));
      check($sformatf("vec%0d_y", i), 32'(DrawY_d), 32'(5 * i + 2));
    end

    // Streaming: a new pixel every cycle, output must trail by exactly two cycles.
    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 0) begin
        drive(1'b0, 1'b1, 4'b0001, 16'hD975, 4'b0000, 10'(100 + k), 10'(300 - k));
        exp_q.push_back({4'd5, LAYER_PLAYER, 10'(100 + k), 10'(300 - k)});
      end else begin
        drive(1'b0, 1'b1, 4'b0100, 16'hD975, 4'b0000, 10'(100 + k), 10'(300 - k));
        exp_q.push_back({4'd9, LAYER_ENEMY, 10'(100 + k), 10'(300 - k)});
      end
      tick();
      if (k >= 1) begin
        e = exp_q.pop_front();
        check_pix($sformatf("stream%0d", k), e[25:22], e[21:20]);
        check($sformatf("stream%0d_x", k), 32'(DrawX_d), 32'(e[19:10]));
        check($sformatf("stream%0d_y", k), 32'(DrawY_d), 32'(e[9:0]));
      end
    end
    tick();
    e = exp_q.pop_front();
    check_pix("stream_last", e[25:22], e[21:20]);
    check("stream_last_x", 32'(DrawX_d), 32'(e[19:10]));

    // Enable change mid-frame only takes effect after the next frame_start pixel.
    do_reset();
    layer_en_next = 4'b1110;
    drive(1'b0, 1'b1, 4'b1111, 16'hD975, 4'b0000, 10'd50, 10'd60);
    tick(); tick();
    check_pix("en_midframe", 4'd5, LAYER_PLAYER);
    drive(1'b1, 1'b1, 4'b1111, 16'hD975, 4'b0000, 10'd0, 10'd0);
    tick();
    drive(1'b0, 1'b1, 4'b1111, 16'hD975, 4'b0000, 10'd1, 10'd0);
    tick();
    check_pix("en_fs_pixel", 4'd5, LAYER_PLAYER);
    tick();
    check_pix("en_after_fs", 4'd7, LAYER_BULLET);

    // Flash on layer 0: hidden on odd counts, visible for even counts and after expiry.
    do_reset();
    drive(1'b0, 1'b1, 4'b0011, 16'hD975, 4'b0001, 10'd1, 10'd1);
    tick();
    drive(1'b0, 1'b1, 4'b0011, 16'hD975, 4'b0000, 10'd2, 10'd2);
    tick(); tick();
    check_pix("flash_cnt16", 4'd5, LAYER_PLAYER);
    for (int f = 1; f <= 17; f++) begin
      int cnt;
      cnt = (f <= 16) ? 16 - f : 0;
      drive(1'b1, 1'b1, 4'b0011, 16'hD975, 4'b0000, 10'd0, 10'd0);
      tick();
      drive(1'b0, 1'b1, 4'b0011, 16'hD975, 4'b0000, 10'd3, 10'd3);
      tick(); tick();
      if (cnt % 2 == 1) check_pix($sformatf("flash_f%0d", f), 4'd7, LAYER_BULLET);
      else              check_pix($sformatf("flash_f%0d", f), 4'd5, LAYER_PLAYER);
    end
    // Load coincident with frame_start: counter must sit at 16, not 15.
    drive(1'b1, 1'b1, 4'b0011, 16'hD975, 4'b0001, 10'd0, 10'd0);
    tick();
    drive(1'b0, 1'b1, 4'b0011, 16'hD975, 4'b0000, 10'd4, 10'd4);
    tick(); tick();
    check_pix("flash_coinc16", 4'd5, LAYER_PLAYER);
    drive(1'b1, 1'b1, 4'b0011, 16'hD975, 4'b0000, 10'd0, 10'd0);
    tick();
    drive(1'b0, 1'b1, 4'b0011, 16'hD975, 4'b0000, 10'd5, 10'd5);
    tick(); tick();
    check_pix("flash_coinc15", 4'd7, LAYER_BULLET);
    // Restart while flashing goes back to 16.
    drive(1'b0, 1'b1, 4'b0011, 16'hD975, 4'b0001, 10'd6, 10'd6);
    tick();
    drive(1'b0, 1'b1, 4'b0011, 16'hD975, 4'b0000, 10'd7, 10'd7);
    tick(); tick();
    check_pix("flash_restart16", 4'd5, LAYER_PLAYER);
    drive(1'b1, 1'b1, 4'b0011, 16'hD975, 4'b0000, 10'd0, 10'd0);
    tick();
    drive(1'b0, 1'b1, 4'b0011, 16'hD975, 4'b0000, 10'd8, 10'd8);
    tick(); tick();
    check_pix("flash_restart15", 4'd7, LAYER_BULLET);

    // Collision reporting across frames, including an overlap on the frame_start pixel.
    do_reset();
    drive(1'b1, 1'b1, 4'b0000, 16'hD975, 4'b0000, 10'd0, 10'd0);
    tick();
    check_coll("coll_f0", 4'b0000, 1'b1);
    drive(1'b0, 1'b1, 4'b0110, 16'hD975, 4'b0000, 10'd1, 10'd0);
    tick();
    check("coll_pulse_end", 32'(collide_valid), 32'd0);
    drive(1'b0, 1'b1, 4'b0110, 16'hD975, 4'b0000, 10'd2, 10'd0);
    tick();
    drive(1'b0, 1'b1, 4'b0110, 16'hD975, 4'b0000, 10'd3, 10'd0);
    tick();
    drive(1'b0, 1'b0, 4'b1001, 16'hD975, 4'b0000, 10'd4, 10'd0);
    tick();
    drive(1'b0, 1'b1, 4'b0011, 16'hD970, 4'b0000, 10'd5, 10'd0);
    tick();
    drive(1'b0, 1'b1, 4'b0001, 16'hD975, 4'b0000, 10'd6, 10'd0);
    tick();
    drive(1'b1, 1'b1, 4'b0000, 16'hD975, 4'b0000, 10'd0, 10'd0);
    tick();
    check_coll("coll_fN", 4'b0110, 1'b1);
    drive(1'b0, 1'b1, 4'b1000, 16'hD975, 4'b0000, 10'd1, 10'd0);
    tick();
    check_coll("coll_hold", 4'b0110, 1'b0);
    drive(1'b0, 1'b1, 4'b0100, 16'hD975, 4'b0000, 10'd2, 10'd0);
    tick();
    drive(1'b1, 1'b1, 4'b0000, 16'hD975, 4'b0000, 10'd0, 10'd0);
    tick();
    check_coll("coll_fN1", 4'b0000, 1'b1);
    drive(1'b0, 1'b1, 4'b0000, 16'hD975, 4'b0000, 10'd1, 10'd0);
    tick();
    drive(1'b1, 1'b1, 4'b1001, 16'hD975, 4'b0000, 10'd0, 10'd0);
    tick();
    check_coll("coll_fs_pixel", 4'b0000, 1'b1);
    drive(1'b0, 1'b1, 4'b0000, 16'hD975, 4'b0000, 10'd1, 10'd0);
    tick(); tick();
    drive(1'b1, 1'b1, 4'b0000, 16'hD975, 4'b0000, 10'd0, 10'd0);
    tick();
    check_coll("coll_fs_next", 4'b1001, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_miss);
    $finish;
  end

endmodule

// File: doc/sprite_layer_arbiter.md
Name: sprite_layer_arbiter

Overview:
- Per-pixel compositor placed directly upstream of color_mapper.
- Each cycle it receives a hit flag and a 4-bit palette index from NUM_LAYERS sprite sources (player, enemies, bullets) and selects the highest-priority opaque layer. The result drives color_mapper's sprite_data input.
- Also owns frame-synchronous layer enables, a per-layer damage-flash (blink) scheduler and per-frame overlap/collision reporting for game logic.

Parameters:
- NUM_LAYERS, 4, number of sprite sources; index 0 = highest priority.
- FLASH_FRAMES, 16, frames a layer blinks after a flash request (1..255).
- IDX_W, 4, palette index width; must match color_mapper.

Ports:
- Clk  in  1  pixel-domain clock
- Reset  in  1  synchronous, active-high reset
- frame_start  in  1  one-cycle pulse at the first pixel of each frame
- in_active  in  1  current pixel lies in the visible region
- DrawX  in  10  current pixel x
- DrawY  in  10  current pixel y
- layer_hit  in  NUM_LAYERS  layer i covers the current pixel
- layer_index  in  NUM_LAYERS*IDX_W  palette index of layer i, packed with layer i at [i*IDX_W +: IDX_W]
- layer_en_next  in  NUM_LAYERS  requested enables, applied at next frame_start
- flash_req  in  NUM_LAYERS  one-cycle pulse that starts blinking layer i
- sprite_data  out  IDX_W  composited palette index; 0 = background
- win_layer  out  2  layer id that produced sprite_data; 0 when background
- DrawX_d  out  10  DrawX delayed to align with sprite_data
- DrawY_d  out  10  DrawY delayed to align with sprite_data
- collide_mask  out  NUM_LAYERS  previous frame's overlap result, held for a whole frame
- collide_valid  out  1  one-cycle pulse when collide_mask updates

Behaviour:
- Opacity: layer i is opaque when layer_hit[i]=1, layer_index[i]!=0, en_active[i]=1, its flash is not hiding it and in_active=1.
- Stage 1 (registered):
  - Compute an opaque vector from the inputs.
  - Capture layer_index, DrawX and DrawY.
- Stage 2 (registered):
  - Fixed-priority select: lowest-numbered opaque layer wins.
  - sprite_data = that layer's index; win_layer = its id.
  - No opaque layer: sprite_data=0, win_layer=0.
- Latency: exactly 2 Clk cycles from inputs to sprite_data, win_layer, DrawX_d and DrawY_d. Fully pipelined: one pixel per cycle, no stalls.
- Enables:
  - en_active loads layer_en_next on the frame_start cycle; it is constant otherwise.
  - A change mid-frame never tears the frame.
- Flash scheduler: one counter per layer, width ceil(log2(FLASH_FRAMES+1)).
  - flash_req[i] loads FLASH_FRAMES.
  - On frame_start the counter decrements if nonzero.
  - The layer is hidden when its counter is nonzero and counter[0]=1.
  - flash_req and frame_start in the same cycle: the load wins and no decrement occurs.
  - flash_req while already flashing: restart at FLASH_FRAMES.
- Collision accumulator (acc):
  - In stage 1, if popcount(opaque)>=2, OR the opaque vector into acc.
  - On frame_start: collide_mask <= acc; collide_valid=1 for one cycle.
  - On the same cycle, acc <= the frame_start pixel's own contribution (0 if fewer than 2 opaque). Nothing is lost across the boundary.
  - Pixels with in_active=0 never contribute.
- Reset values:
  - sprite_data=0, win_layer=0, DrawX_d=0, DrawY_d=0.
  - collide_mask=0, collide_valid=0, acc=0.
  - en_active=all ones; flash counters=0.
  - Pipeline registers are cleared, so the first 2 post-reset outputs are background.
- Reset mid-frame: the next frame_start behaves normally. The first reported collide_mask covers only the partial frame.
- Layer index 0 is always transparent, even with layer_hit=1.

Decomposition:
- Shared package sprite_pkg:
  - IDX_W, NUM_LAYERS, TRANSPARENT_IDX=0, FLASH_FRAMES.
  - Typedef palette_idx_t (logic [IDX_W-1:0]).
  - Typedef layer_vec_t (logic [NUM_LAYERS-1:0]).
  - Layer-id constants LAYER_PLAYER=0, LAYER_BULLET=1, LAYER_ENEMY=2, LAYER_FX=3.
- One sub-module, flash_timer: a single counter with load, frame-decrement and hide outputs, instantiated NUM_LAYERS times via generate.

Test Plan:
- Reset, then drive all hits=1 with indices {5,7,9,13}, en=all ones, in_active=1 -> after 2 cycles sprite_data=5, win_layer=0; DrawX_d equals DrawX from 2 cycles earlier.
- Layer0 hit with index 0, layer2 hit with index 9 -> sprite_data=9, win_layer=2. in_active=0 -> sprite_data=0.
- layer_en_next=4'b1110 asserted mid-frame -> layer 0 still wins until frame_start; from the next pixel after frame_start, layer 1 wins.
- flash_req[0] pulse, then 16 frame_starts -> layer 0 hidden in frames where counter is odd (15,13,...,1), visible in even frames, permanently visible after counter=0. flash_req coincident with frame_start -> counter=16, no decrement.
- Layers 1 and 2 overlap on 3 pixels in frame N, no overlap in frame N+1 -> at frame N+1 start, collide_valid pulses with collide_mask=4'b0110. At frame N+2 start, collide_mask=0.
- Overlap exactly on the frame_start pixel -> that overlap appears in the following frame's report, not the current one.
